q_format: RTL and testbench
===========================

Q_FORMAT -- requirements
Module: q_format

Interface
REQ-001 Parameter FIXED_BITS, default 8, SHALL set the number of signed integer bits, sign bit included.
REQ-002 Parameter FRACTIONAL_BITS, default 8, SHALL set the number of fraction bits; W = FIXED_BITS + FRACTIONAL_BITS.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mark a, b and op as a valid operation request in the current cycle.
REQ-007 a  input  W  SHALL be signed operand A in Q(FIXED_BITS).(FRACTIONAL_BITS) format.
REQ-008 b  input  W  SHALL be signed operand B in the same Q format.
REQ-009 op  input  2  SHALL select the operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 result  output  W  SHALL be the registered signed Q-format result.
REQ-011 out_valid  output  1  SHALL pulse high for one cycle when result is updated.
REQ-012 ovf  output  1  SHALL flag that the exact result was out of range for W bits.
REQ-013 dz  output  1  SHALL flag a divide by zero.

Function
REQ-014 Latency SHALL be 1 cycle: in_valid sampled at edge N -> result/flags/out_valid at edge N; no backpressure; a new request is accepted every cycle.
REQ-015 When in_valid=0, out_valid SHALL be 0 and result, ovf and dz SHALL hold their previous values.
REQ-016 add SHALL compute a+b at W+1 bits, and sub SHALL compute a-b at W+1 bits.
REQ-017 mul SHALL form the full 2W-bit signed product and arithmetic-shift it right by FRACTIONAL_BITS (truncate toward minus infinity).
REQ-018 div SHALL compute (a sign-extended and shifted left by FRACTIONAL_BITS) / b as a signed quotient truncated toward zero.
REQ-019 Divide by zero (op=11, b=0) SHALL give result=0, dz=1 and ovf=0.
REQ-020 dz SHALL be 0 for every non-divide-by-zero operation.
REQ-021 ovf SHALL be 1 when the exact intermediate lies outside [-2^(W-1), 2^(W-1)-1], including div of the most negative value by -1.0.
REQ-022 On overflow, result SHALL follow REQ-027.
REQ-023 Simultaneous rst and in_valid: reset SHALL win.

Reset
REQ-024 While rst=1, result SHALL be 0, out_valid 0, ovf 0 and dz 0, immediately and independent of clk.
REQ-025 A request accepted in the cycle reset asserts SHALL be discarded.
REQ-026 The first request SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro Q_FORMAT_SAT_EN selects overflow handling.
- Defined: an overflowing result SHALL clamp to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow).
- Undefined: an overflowing result SHALL wrap to the low W bits.
- ovf SHALL behave identically in both cases.

Structure
REQ-028 Package q_format_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) as a 2-bit typedef, plus the default width constants.
REQ-029 Division SHALL be a combinational sub-module q_format_div (signed restoring or non-restoring array divider, quotient and divide-by-zero outputs), instantiated once.

Verification (default parameters, Q8.8)
REQ-030 add: a=0x0180 (1.5), b=0x0240 (2.25) -> result=0x03C0 (3.75), ovf=0, dz=0, out_valid high one cycle later.
REQ-031 sub: a=0x0580 (5.5), b=0x0240 -> 0x0340 (3.25); negative add: a=0xFD80 (-2.5), b=0x0100 -> 0xFE80 (-1.5).
REQ-032 mul: a=0x0180, b=0x0200 (2.0) -> 0x0300 (3.0); mul of 0xFF00 (-1.0) by 0x0080 (0.5) -> 0xFF80.
REQ-033 div: a=0x0300 (3.0), b=0x0180 (1.5) -> 0x0200 (2.0); a=0x0300, b=0 -> result 0x0000, dz=1.
REQ-034 Overflow add: a=0x7F00, b=0x0100 -> ovf=1; result 0x7FFF with Q_FORMAT_SAT_EN defined, 0x8000 without.
REQ-035 Reset mid-stream: assert rst asynchronously between edges -> result=0 and out_valid=0 immediately; with in_valid=0 after release, result holds 0.

Source files
------------

// File: rtl/q_format_pkg.sv
// rtl/q_format_pkg.sv - op encodings and default Q8.8 widths for q_format
package q_format_pkg;

  localparam int DEF_FIXED_BITS      = 8;
  localparam int DEF_FRACTIONAL_BITS = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

endpackage

// File: rtl/q_format_div.sv
// rtl/q_format_div.sv - combinational signed restoring array divider
// Quotient truncates toward zero; one extra bit holds the +2^(NW-1) magnitude case.
module q_format_div #(
  parameter int NW = 24,
  parameter int DW = 16
) (
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [NW:0]   quot,
  output logic          dz
);

  logic [NW-1:0] n_mag;
  logic [DW-1:0] d_mag;
  logic [DW:0]   rem;
  logic [NW-1:0] q_mag;
  logic [NW:0]   q_ext;
  logic          neg;

  always_comb begin
    n_mag = num[NW-1] ? (~num + NW'(1)) : num;
    d_mag = den[DW-1] ? (~den + DW'(1)) : den;
    neg   = num[NW-1] ^ den[DW-1];
    dz    = (den == '0);
    rem   = '0;
    q_mag = '0;
    // One restoring row per dividend bit, MSB first.
    for (int i = NW - 1; i >= 0; i--) begin
      rem = {rem[DW-1:0], n_mag[i]};
      if (rem >= {1'b0, d_mag}) begin
        rem      = rem - {1'b0, d_mag};
        q_mag[i] = 1'b1;
      end
    end
    q_ext = {1'b0, q_mag};
    if (dz) begin
      quot = '0;
    end else if (neg) begin
      quot = ~q_ext + (NW + 1)'(1);
    end else begin
      quot = q_ext;
    end
  end

endmodule

// File: rtl/q_format.sv
// rtl/q_format.sv - registered signed Q-format add/sub/mul/div, one-cycle latency
// Q_FORMAT_SAT_EN: clamp overflowing results instead of wrapping to the low W bits.
module q_format
  import q_format_pkg::*;
#(
  parameter int FIXED_BITS      = DEF_FIXED_BITS,
  parameter int FRACTIONAL_BITS = DEF_FRACTIONAL_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [FIXED_BITS+FRACTIONAL_BITS-1:0] a,
  input  logic [FIXED_BITS+FRACTIONAL_BITS-1:0] b,
  input  logic [1:0]                            op,
  output logic [FIXED_BITS+FRACTIONAL_BITS-1:0] result,
  output logic                                  out_valid,
  output logic                                  ovf,
  output logic                                  dz
);

  localparam int W  = FIXED_BITS + FRACTIONAL_BITS;
  localparam int FR = FRACTIONAL_BITS;
  localparam int QW = W + FR + 1;
  // Wide enough for the full product and the largest quotient.
  localparam int WX = 2 * W + 2;

  logic signed [WX-1:0] a_x, b_x, prod_x, exact;
  logic [QW-1:0]        div_q;
  logic                 div_dz;
  logic                 ovf_raw;
  logic [W-1:0]         sat_val;

  logic [W-1:0] result_d, result_q;
  logic         out_valid_d, out_valid_q;
  logic         ovf_d, ovf_q;
  logic         dz_d, dz_q;

  q_format_div #(
    .NW(W + FR),
    .DW(W)
  ) u_div (
    .num  ({a, {FR{1'b0}}}),
    .den  (b),
    .quot (div_q),
    .dz   (div_dz)
  );

  assign a_x    = {{(WX-W){a[W-1]}}, a};
  assign b_x    = {{(WX-W){b[W-1]}}, b};
  assign prod_x = a_x * b_x;

  always_comb begin
    exact = '0;
    case (op_e'(op))
      OP_ADD: exact = a_x + b_x;
      OP_SUB: exact = a_x - b_x;
      OP_MUL: exact = prod_x >>> FR;
      OP_DIV: exact = {{(WX-QW){div_q[QW-1]}}, div_q};
      default: exact = '0;
    endcase
    // In range exactly when every bit from W-1 upward matches the sign.
    ovf_raw = !((&exact[WX-1:W-1]) || (~|exact[WX-1:W-1]));
    sat_val = exact[WX-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_comb begin
    result_d    = result_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      if ((op_e'(op) == OP_DIV) && div_dz) begin
        result_d = '0;
        ovf_d    = 1'b0;
        dz_d     = 1'b1;
      end else begin
        dz_d  = 1'b0;
        ovf_d = ovf_raw;
`ifdef Q_FORMAT_SAT_EN
        result_d = ovf_raw ? sat_val : exact[W-1:0];
`else
        result_d = exact[W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_q_format.sv
// tb/tb_q_format.sv - directed self-checking bench for q_format (Q8.8)
module tb_q_format;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic [15:0] result;
  logic        out_valid;
  logic        ovf;
  logic        dz;

  int checks;
  int errors;

  q_format dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .out_valid (out_valid),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {result, out_valid, ovf, dz}.
  logic [18:0] got;
  assign got = {result, out_valid, ovf, dz};

  task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic [1:0] opi);
    a        = ai;
    b        = bi;
    op       = opi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    #1;
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, 19'h0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_release_idle got=%h exp=%h", got, 19'h0);
    end
  endtask

  task automatic test_add_sub();
    issue(16'h0180, 16'h0240, 2'b00);
    checks++;
    if (got !== {16'h03C0, 3'b100}) begin
      errors++;
      $display("FAIL add_pos got=%h exp=%h", got, {16'h03C0, 3'b100});
    end
    idle_cycle();
    checks++;
    if (got !== {16'h03C0, 3'b000}) begin
      errors++;
      $display("FAIL hold_idle got=%h exp=%h", got, {16'h03C0, 3'b000});
    end
    issue(16'h0580, 16'h0240, 2'b01);
    checks++;
    if (got !== {16'h0340, 3'b100}) begin
      errors++;
      $display("FAIL sub got=%h exp=%h", got, {16'h0340, 3'b100});
    end
    issue(16'hFD80, 16'h0100, 2'b00);
    checks++;
    if (got !== {16'hFE80, 3'b100}) begin
      errors++;
      $display("FAIL add_neg got=%h exp=%h", got, {16'hFE80, 3'b100});
    end
  endtask

  task automatic test_mul();
    issue(16'h0180, 16'h0200, 2'b10);
    checks++;
    if (got !== {16'h0300, 3'b100}) begin
      errors++;
      $display("FAIL mul_pos got=%h exp=%h", got, {16'h0300, 3'b100});
    end
    issue(16'hFF00, 16'h0080, 2'b10);
    checks++;
    if (got !== {16'hFF80, 3'b100}) begin
      errors++;
      $display("FAIL mul_neg got=%h exp=%h", got, {16'hFF80, 3'b100});
    end
    // -1/256 * 0.5 = -1/512 floors to -1/256.
    issue(16'hFFFF, 16'h0080, 2'b10);
    checks++;
    if (got !== {16'hFFFF, 3'b100}) begin
      errors++;
      $display("FAIL mul_floor got=%h exp=%h", got, {16'hFFFF, 3'b100});
    end
  endtask

  task automatic test_div();
    issue(16'h0300, 16'h0180, 2'b11);
    checks++;
    if (got !== {16'h0200, 3'b100}) begin
      errors++;
      $display("FAIL div_pos got=%h exp=%h", got, {16'h0200, 3'b100});
    end
    // -1.0 / 3.0 = -85.33/256 truncates toward zero to -85/256.
    issue(16'hFF00, 16'h0300, 2'b11);
    checks++;
    if (got !== {16'hFFAB, 3'b100}) begin
      errors++;
      $display("FAIL div_trunc got=%h exp=%h", got, {16'hFFAB, 3'b100});
    end
    issue(16'h0300, 16'h0000, 2'b11);
    checks++;
    if (got !== {16'h0000, 3'b101}) begin
      errors++;
      $display("FAIL div_zero got=%h exp=%h", got, {16'h0000, 3'b101});
    end
    issue(16'h0100, 16'h0100, 2'b00);
    checks++;
    if (got !== {16'h0200, 3'b100}) begin
      errors++;
      $display("FAIL dz_clear got=%h exp=%h", got, {16'h0200, 3'b100});
    end
  endtask

  task automatic test_overflow();
    logic [15:0] e_add, e_sub, e_div, e_mul;
`ifdef Q_FORMAT_SAT_EN
    e_add = 16'h7FFF; e_sub = 16'h8000; e_div = 16'h7FFF; e_mul = 16'h7FFF;
`else
    e_add = 16'h8000; e_sub = 16'h7F00; e_div = 16'h8000; e_mul = 16'h8000;
`endif
    issue(16'h7F00, 16'h0100, 2'b00);
    checks++;
    if (got !== {e_add, 3'b110}) begin
      errors++;
      $display("FAIL ovf_add got=%h exp=%h", got, {e_add, 3'b110});
    end
    issue(16'h8000, 16'h0100, 2'b01);
    checks++;
    if (got !== {e_sub, 3'b110}) begin
      errors++;
      $display("FAIL ovf_sub_neg got=%h exp=%h", got, {e_sub, 3'b110});
    end
    issue(16'h8000, 16'hFF00, 2'b11);
    checks++;
    if (got !== {e_div, 3'b110}) begin
      errors++;
      $display("FAIL ovf_div_min got=%h exp=%h", got, {e_div, 3'b110});
    end
    issue(16'h4000, 16'h0200, 2'b10);
    checks++;
    if (got !== {e_mul, 3'b110}) begin
      errors++;
      $display("FAIL ovf_mul got=%h exp=%h", got, {e_mul, 3'b110});
    end
    issue(16'h7FFF, 16'h0000, 2'b00);
    checks++;
    if (got !== {16'h7FFF, 3'b100}) begin
      errors++;
      $display("FAIL add_max_edge got=%h exp=%h", got, {16'h7FFF, 3'b100});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [1:0]  vo [4];
    logic [15:0] ve [4];
    va = '{16'h0100, 16'h0400, 16'h0200, 16'h0800};
    vb = '{16'h0100, 16'h0100, 16'h0300, 16'h0200};
    vo = '{2'b00,    2'b01,    2'b10,    2'b11};
    ve = '{16'h0200, 16'h0300, 16'h0600, 16'h0400};
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vo[i]);
      checks++;
      if (got !== {ve[i], 3'b100}) begin
        errors++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, got, {ve[i], 3'b100});
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    issue(16'h0100, 16'h0200, 2'b00);
    a = 16'h0500; b = 16'h0100; op = 2'b00; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", got, 19'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_wins got=%h exp=%h", got, 19'h0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();
    idle_cycle();
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_hold_zero got=%h exp=%h", got, 19'h0);
    end
    issue(16'h0180, 16'h0240, 2'b00);
    checks++;
    if (got !== {16'h03C0, 3'b100}) begin
      errors++;
      $display("FAIL first_after_reset got=%h exp=%h", got, {16'h03C0, 3'b100});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_overflow();
    test_back_to_back();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
